comparator_seq_ctrl: RTL and testbench

Sequencing controller that compares two WIDTH-bit unsigned operands using the team's 2-bit/2-bit comparator, one digit per cycle. It accepts an operand pair over a valid/ready handshake and drives one 2-bit digit pair per cycle, MSB digit first, onto the comparator inputs A, B, C and D. It reads the comparator's F1/F2/F3 flags back, stops at the first unequal digit, and returns a registered greater/less/equal result over a second valid/ready handshake. The controller sits directly upstream of the comparator and also consumes its outputs.

---
 rtl/comparator_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_comparator_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : comparator_seq_ctrl
// Description : Feeds two WIDTH-bit operands, MSB digit first, through an
//               external 2-bit comparator and returns gt/lt/eq/err.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                x,
    input  logic [WIDTH-1:0]                y,
    output logic                            cmp_a,
    output logic                            cmp_b,
    output logic                            cmp_c,
    output logic                            cmp_d,
    input  logic                            cmp_f1,
    input  logic                            cmp_f2,
    input  logic                            cmp_f3,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            gt,
    output logic                            lt,
    output logic                            eq,
    output logic                            err,
    output logic [$clog2(WIDTH/2+1)-1:0]    ncmp
);

    localparam int c_NDIG = WIDTH / 2;
    localparam int c_IW   = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
    localparam int c_CW   = $clog2(c_NDIG + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CMP  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]       r_state, w_state;
    logic [WIDTH-1:0] r_x, w_x;
    logic [WIDTH-1:0] r_y, w_y;
    logic [c_IW-1:0]  r_idx, w_idx;
    logic [c_CW-1:0]  r_cnt, w_cnt;
    logic             r_gt, w_gt;
    logic             r_lt, w_lt;
    logic             r_eq, w_eq;
    logic             r_err, w_err;
    logic             r_out_valid, w_out_valid;

    logic [1:0]       w_xd;
    logic [1:0]       w_yd;
    logic             w_in_cmp;
    logic             w_onehot;

    assign w_in_cmp = (r_state == c_ST_CMP);
    assign w_xd     = r_x[{r_idx, 1'b0} +: 2];
    assign w_yd     = r_y[{r_idx, 1'b0} +: 2];
    assign w_onehot = (cmp_f1 ^ cmp_f2 ^ cmp_f3) & ~(cmp_f1 & cmp_f2 & cmp_f3);

    assign cmp_a     = w_in_cmp & w_xd[1];
    assign cmp_b     = w_in_cmp & w_xd[0];
    assign cmp_c     = w_in_cmp & w_yd[1];
    assign cmp_d     = w_in_cmp & w_yd[0];
    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = r_out_valid;
    assign gt        = r_gt;
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign err       = r_err;
    assign ncmp      = r_cnt;

    always_comb begin
        w_state     = r_state;
        w_x         = r_x;
        w_y         = r_y;
        w_idx       = r_idx;
        w_cnt       = r_cnt;
        w_gt        = r_gt;
        w_lt        = r_lt;
        w_eq        = r_eq;
        w_err       = r_err;
        w_out_valid = r_out_valid;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_x     = x;
                    w_y     = y;
                    w_idx   = c_IW'(c_NDIG - 1);
                    w_cnt   = '0;
                    w_gt    = 1'b0;
                    w_lt    = 1'b0;
                    w_eq    = 1'b0;
                    w_err   = 1'b0;
                    w_state = c_ST_CMP;
                end
            end
            c_ST_CMP: begin
                // Flags come straight back from the comparator this cycle.
                w_cnt = r_cnt + c_CW'(1);
                if (!w_onehot) begin
                    w_err   = 1'b1;
                    w_state = c_ST_DONE;
                end else if (cmp_f3) begin
                    w_gt    = 1'b1;
                    w_state = c_ST_DONE;
                end else if (cmp_f2) begin
                    w_lt    = 1'b1;
                    w_state = c_ST_DONE;
                end else if (r_idx == '0) begin
                    w_eq    = 1'b1;
                    w_state = c_ST_DONE;
                end else begin
                    w_idx = r_idx - c_IW'(1);
                end
            end
            c_ST_DONE: begin
                // out_valid is raised one cycle after entering DONE.
                if (!r_out_valid) begin
                    w_out_valid = 1'b1;
                end else if (out_ready) begin
                    w_out_valid = 1'b0;
                    w_state     = c_ST_IDLE;
                end
            end
            default: begin
                w_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_x         <= w_x;
            r_y         <= w_y;
            r_idx       <= w_idx;
            r_cnt       <= w_cnt;
            r_gt        <= w_gt;
            r_lt        <= w_lt;
            r_eq        <= w_eq;
            r_err       <= w_err;
            r_out_valid <= w_out_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_comparator_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator_seq_ctrl
// Description : Bench for comparator_seq_ctrl with a behavioural comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_seq_ctrl;

    localparam int WIDTH  = 8;
    localparam int c_NDIG = WIDTH / 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cmp_a, cmp_b, cmp_c, cmp_d;
    logic             cmp_f1, cmp_f2, cmp_f3;
    logic             out_valid;
    logic             out_ready;
    logic             gt, lt, eq, err;
    logic [2:0]       ncmp;

    int               n_chk;
    int               n_err;
    int               fault_dig;
    int               cur_cyc;
    logic [2:0]       fault_flags;
    logic [1:0]       w_xd, w_yd;

    comparator_seq_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_c     (cmp_c),
        .cmp_d     (cmp_d),
        .cmp_f1    (cmp_f1),
        .cmp_f2    (cmp_f2),
        .cmp_f3    (cmp_f3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .err       (err),
        .ncmp      (ncmp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator stand-in, with optional bad flags on one chosen digit.
    always_comb begin
        w_xd = {cmp_a, cmp_b};
        w_yd = {cmp_c, cmp_d};
        {cmp_f3, cmp_f2, cmp_f1} = {w_xd > w_yd, w_xd < w_yd, w_xd == w_yd};
        if (fault_dig != 0 && cur_cyc == fault_dig)
            {cmp_f3, cmp_f2, cmp_f1} = fault_flags;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] dig(input logic [WIDTH-1:0] v, input int j);
        int vv;
        vv = int'(v);
        return 2'((vv >> (WIDTH - 2 - 2 * j)) & 3);
    endfunction

    task automatic run(input logic [WIDTH-1:0] vx, input logic [WIDTH-1:0] vy,
                       input int hold, input int fdig, input logic [2:0] fflags);
        int         k;
        int         j;
        int         w;
        logic [3:0] e_res;
        logic       seq_ok;
        logic       stable;
        logic [6:0] snap;

        k = c_NDIG;
        for (int i = 0; i < c_NDIG; i++) begin
            if (dig(vx, i) != dig(vy, i)) begin
                k = i + 1;
                break;
            end
        end
        e_res = {vx > vy, vx < vy, vx == vy, 1'b0};
        if (fdig != 0 && fdig <= k) begin
            k     = fdig;
            e_res = 4'b0001;
        end
        fault_dig   = fdig;
        fault_flags = fflags;

        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);

        x        = vx;
        y        = vy;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x        = WIDTH'($urandom);
        y        = WIDTH'($urandom);

        j      = 0;
        seq_ok = 1'b1;
        while (!out_valid && j < c_NDIG + 3) begin
            cur_cyc = j + 1;
            if (j < k) begin
                if ({cmp_a, cmp_b, cmp_c, cmp_d} !== {dig(vx, j), dig(vy, j)})
                    seq_ok = 1'b0;
            end else if ({cmp_a, cmp_b, cmp_c, cmp_d} !== 4'b0000) begin
                seq_ok = 1'b0;
            end
            if (in_ready)
                seq_ok = 1'b0;
            @(negedge clk);
            j++;
        end
        cur_cyc = 0;

        chk("digit_seq", 32'(seq_ok), 32'd1);
        chk("latency", 32'(j), 32'(k + 1));
        chk("result", 32'({gt, lt, eq, err}), 32'(e_res));
        chk("ncmp", 32'(ncmp), 32'(k));

        snap   = {gt, lt, eq, err, ncmp};
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            x        = WIDTH'($urandom);
            y        = WIDTH'($urandom);
            @(negedge clk);
            if (!out_valid || in_ready || {gt, lt, eq, err, ncmp} !== snap)
                stable = 1'b0;
        end
        if (hold > 0)
            chk("backpressure", 32'(stable), 32'd1);

        out_ready = 1'b1;
        @(negedge clk);
        chk("release", 32'({out_valid, in_ready}), 32'b01);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] rx, ry;
        logic [2:0]       rf;
        int               mode;
        int               fd;
        logic             seen;

        n_chk       = 0;
        n_err       = 0;
        fault_dig   = 0;
        cur_cyc     = 0;
        fault_flags = 3'b000;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        x           = '0;
        y           = '0;

        repeat (2) @(negedge clk);
        chk("reset_state",
            32'({in_ready, out_valid, gt, lt, eq, err, ncmp, cmp_a, cmp_b, cmp_c, cmp_d}),
            32'h1000);
        rst_n = 1'b1;
        @(negedge clk);

        run(8'hB4, 8'hB1, 0, 0, 3'b000);
        run(8'h12, 8'h92, 0, 0, 3'b000);
        run(8'h5A, 8'h5A, 6, 0, 3'b000);
        run(8'h5A, 8'h5A, 0, 2, 3'b000);
        run(8'h3C, 8'h3C, 1, 2, 3'b110);

        // Reset in the second CMP cycle discards the comparison.
        x        = 8'hB4;
        y        = 8'hB1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_reset",
            32'({in_ready, out_valid, gt, lt, eq, err, ncmp, cmp_a, cmp_b, cmp_c, cmp_d}),
            32'h1000);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid)
                seen = 1'b1;
        end
        chk("no_result_after_rst", 32'(seen), 32'd0);
        run(8'h00, 8'h01, 0, 0, 3'b000);

        repeat (40) begin
            rx   = WIDTH'($urandom);
            mode = $urandom_range(0, 2);
            case (mode)
                0:       ry = WIDTH'($urandom);
                1:       ry = rx ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: ry = rx;
            endcase
            fd = 0;
            rf = 3'b000;
            if ($urandom_range(0, 7) == 0) begin
                fd = $urandom_range(1, c_NDIG);
                do
                    rf = 3'($urandom_range(0, 7));
                while ($countones(rf) == 1);
            end
            run(rx, ry, $urandom_range(0, 3), fd, rf);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
